// File: rtl/sha256_compression_core_if.sv
// Block-level bus between the hash controller / message scheduler and the compression core.
// The master drives start, h_in and the W_t stream; the slave returns handshake, status and digest.
interface sha256_compression_core_if;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_t;
  logic         w_valid;
  logic         w_ready;
  logic [5:0]   round_idx;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;
  logic         done;

  modport master (
    output start, h_in, w_t, w_valid,
    input  w_ready, round_idx, busy, digest, digest_valid, done
  );

  modport slave (
    input  start, h_in, w_t, w_valid,
    output w_ready, round_idx, busy, digest, digest_valid, done
  );
endinterface

// File: rtl/sha256_compression_core.sv
// Iterative SHA-256 compression: one round per accepted W_t, then feed-forward into the digest.
// Latency 65 cycles from the start edge plus stall cycles; w_valid low in ROUND freezes all state.
module sha256_compression_core (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  sha256_compression_core_if.slave        io_sha
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  work_t              r_wk;
  work_t              w_wk_nxt;
  logic [7:0][31:0]   r_h;
  logic [5:0]         r_round;
  logic [255:0]       r_digest;
  logic [255:0]       w_sum;
  logic               r_digest_valid;
  logic               r_done;
  logic               w_ready;
  logic               w_busy;
  logic               w_start_acc;
  logic               w_hs;
  logic [31:0]        w_ch;
  logic [31:0]        w_maj;
  logic [31:0]        w_t1;
  logic [31:0]        w_t2;

  // w_ready is a pure state decode so the scheduler never sees a valid->ready loop.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_sha.start) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (io_sha.w_valid && (r_round == 6'd63)) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start_acc = ((r_state == S_IDLE) || (r_state == S_DONE)) && io_sha.start;
  assign w_hs        = w_ready && io_sha.w_valid;

  always_comb begin
    w_ch  = (r_wk.e & r_wk.f) ^ (~r_wk.e & r_wk.g);
    w_maj = (r_wk.a & r_wk.b) ^ (r_wk.a & r_wk.c) ^ (r_wk.b & r_wk.c);
    w_t1  = r_wk.h + big_sigma1(r_wk.e) + w_ch + K_ROM[r_round] + io_sha.w_t;
    w_t2  = big_sigma0(r_wk.a) + w_maj;
    w_wk_nxt.a = w_t1 + w_t2;
    w_wk_nxt.b = r_wk.a;
    w_wk_nxt.c = r_wk.b;
    w_wk_nxt.d = r_wk.c;
    w_wk_nxt.e = r_wk.d + w_t1;
    w_wk_nxt.f = r_wk.e;
    w_wk_nxt.g = r_wk.f;
    w_wk_nxt.h = r_wk.g;
  end

  // Word i of the working struct lines up with H word i, both MSB-first like h_in.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i*32 +: 32] = r_h[i] + r_wk[i*32 +: 32];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_wk           <= '0;
      r_h            <= '0;
      r_round        <= '0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_start_acc) begin
        r_h            <= io_sha.h_in;
        r_wk           <= work_t'(io_sha.h_in);
        r_round        <= '0;
        r_digest       <= '0;
        r_digest_valid <= 1'b0;
      end else if (w_hs) begin
        r_wk    <= w_wk_nxt;
        r_round <= r_round + 6'd1;
      end else if (r_state == S_FINAL) begin
        r_digest       <= w_sum;
        r_digest_valid <= 1'b1;
        r_done         <= 1'b1;
      end
    end
  end

  assign io_sha.w_ready      = w_ready;
  assign io_sha.busy         = w_busy;
  assign io_sha.round_idx    = r_round;
  assign io_sha.digest       = r_digest;
  assign io_sha.digest_valid = r_digest_valid;
  assign io_sha.done         = r_done;

endmodule
